// File: rtl/fetch_decode_queue_pkg.sv
// Shared IF/ID types: machine width, the canonical NOP, and the {pc, instr} packet
// carried from fetch into decode.
package fetch_decode_queue_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_decode_queue_if.sv
// IF->ID queue handshake bundle; slave is the queue's view, master is the view of
// the fetch/decode environment driving it.
interface fetch_decode_queue_if;
  import fetch_decode_queue_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            pc_write;
  logic            flush;
  logic            id_ready;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output pc_write, id_valid, id_pc, id_instr
  );

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  pc_write, id_valid, id_pc, id_instr
  );

endinterface

// File: rtl/fetch_decode_queue_perf_counters.sv
// Saturating event counters for the IF->ID queue: fetch stall cycles and flushes
// that discarded live entries. Counts are registered, one cycle behind the event.
module fetch_decode_queue_perf_counters (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_if_valid,
  input  logic        i_pc_write,
  input  logic        i_flush,
  input  logic        i_occupied,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
);

  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_stall_evt = i_if_valid & ~i_pc_write;
  assign w_flush_evt = i_flush & i_occupied;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush_evt && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/fetch_decode_queue.sv
// IF->ID decoupling FIFO: 1-cycle push-to-head latency, pc_write backpressure from
// registered occupancy only, flush drains everything. FDQ_PERF_CNT_EN adds counters.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  fetch_decode_queue_if.slave  bus
`ifdef FDQ_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count
`endif
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  fetch_pkt_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_pc_write;
  logic             w_id_valid;
  logic             w_push;
  logic             w_pop;
  fetch_pkt_t       w_head;

  // Backpressure is a function of stored occupancy only, so decode stalls never
  // reach the fetch PC mux in the same cycle.
  assign w_pc_write = (r_count != FULL_CNT);
  assign w_id_valid = (r_count != '0);
  assign w_push     = bus.if_valid & w_pc_write & ~bus.flush;
  assign w_pop      = w_id_valid & bus.id_ready & ~bus.flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.if_pc, bus.if_instr};
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign bus.pc_write = w_pc_write;
  assign bus.id_valid = w_id_valid;
  assign bus.id_pc    = w_id_valid ? w_head.pc    : '0;
  assign bus.id_instr = w_id_valid ? w_head.instr : NOP_INSTR;

`ifdef FDQ_PERF_CNT_EN
  fetch_decode_queue_perf_counters u_perf (
    .clk            (clk),
    .resetn         (resetn),
    .i_if_valid     (bus.if_valid),
    .i_pc_write     (w_pc_write),
    .i_flush        (bus.flush),
    .i_occupied     (w_id_valid),
    .o_stall_cycles (stall_cycles),
    .o_flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized + directed bench for fetch_decode_queue at DEPTH=2 and DEPTH=4, each
// instance checked every cycle against a queue-based reference model.
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tb_if_valid = 1'b0;
  logic [31:0] tb_if_pc = '0;
  logic [31:0] tb_if_instr = '0;
  logic        tb_flush = 1'b0;
  logic        tb_id_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 2 : 4;

    fetch_decode_queue_if bus ();
    assign bus.if_valid = tb_if_valid;
    assign bus.if_pc    = tb_if_pc;
    assign bus.if_instr = tb_if_instr;
    assign bus.flush    = tb_flush;
    assign bus.id_ready = tb_id_ready;

`ifdef FDQ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] exp_stall = '0;
    logic [31:0] exp_fcnt = '0;
`endif

    fetch_decode_queue #(.DEPTH(D)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
`ifdef FDQ_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
    );

    // Reference: the set of accepted-but-not-consumed packets, in arrival order.
    fetch_pkt_t exp_q[$];
    int         exp_n = 0;
    fetch_pkt_t exp_head = '0;
    bit         m_full;

    always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        exp_q.delete();
`ifdef FDQ_PERF_CNT_EN
        exp_stall = '0;
        exp_fcnt  = '0;
`endif
      end else begin
        m_full = (exp_q.size() == D);
`ifdef FDQ_PERF_CNT_EN
        if (tb_if_valid && m_full && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
        if (tb_flush && exp_q.size() != 0 && exp_fcnt != 32'hFFFF_FFFF) exp_fcnt = exp_fcnt + 1;
`endif
        if (tb_flush) begin
          exp_q.delete();
        end else begin
          if (tb_id_ready && exp_q.size() != 0) void'(exp_q.pop_front());
          if (tb_if_valid && !m_full) exp_q.push_back({tb_if_pc, tb_if_instr});
        end
      end
      exp_n    = exp_q.size();
      exp_head = (exp_n != 0) ? exp_q[0] : '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic check_inst(input string tag, input int depth, input int n,
                            input fetch_pkt_t head, input logic vld,
                            input logic [31:0] pc, input logic [31:0] instr,
                            input logic pcw);
    chk({tag, "_id_valid"}, 32'(vld), 32'(n != 0));
    chk({tag, "_pc_write"}, 32'(pcw), 32'(n != depth));
    chk({tag, "_id_pc"},    pc,    (n != 0) ? head.pc    : 32'h0);
    chk({tag, "_id_instr"}, instr, (n != 0) ? head.instr : NOP_INSTR);
  endtask

  // Monitor: compares head/backpressure after every edge and on async reset entry.
  initial begin
    forever begin
      @(posedge clk or negedge resetn);
      #1;
      check_inst("d2", 2, g_inst[0].exp_n, g_inst[0].exp_head, g_inst[0].bus.id_valid,
                 g_inst[0].bus.id_pc, g_inst[0].bus.id_instr, g_inst[0].bus.pc_write);
      check_inst("d4", 4, g_inst[1].exp_n, g_inst[1].exp_head, g_inst[1].bus.id_valid,
                 g_inst[1].bus.id_pc, g_inst[1].bus.id_instr, g_inst[1].bus.pc_write);
`ifdef FDQ_PERF_CNT_EN
      chk("d2_stall_cycles", g_inst[0].stall_cycles, g_inst[0].exp_stall);
      chk("d2_flush_count",  g_inst[0].flush_count,  g_inst[0].exp_fcnt);
      chk("d4_stall_cycles", g_inst[1].stall_cycles, g_inst[1].exp_stall);
      chk("d4_flush_count",  g_inst[1].flush_count,  g_inst[1].exp_fcnt);
`endif
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic fl, input logic rdy);
    @(negedge clk);
    tb_if_valid = v;
    tb_if_pc    = pc;
    tb_if_instr = instr;
    tb_flush    = fl;
    tb_id_ready = rdy;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Fill with decode stalled; third offer is refused by the DEPTH=2 queue.
    cyc(1'b1, 32'h0, 32'hA000_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h4, 32'hA000_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'h8, 32'hA000_0003, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming: one push and one pop per cycle.
    for (int k = 0; k < 8; k++) cyc(1'b1, 32'(k * 4), 32'hB000_0000 | 32'(k), 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Full then simultaneous offer and pop.
    cyc(1'b1, 32'h100, 32'hC000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h104, 32'hC000_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h108, 32'hC000_0002, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Flush with a concurrent fetch; the redirect target comes out first.
    cyc(1'b1, 32'h10, 32'hD000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h14, 32'hD000_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 32'hD000_0002, 1'b1, 1'b1);
    cyc(1'b1, 32'h80, 32'hD000_0003, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Random traffic: exercises pointer wrap, stalls and flushes at both depths.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom,
          $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a cycle with entries held.
    cyc(1'b1, 32'h200, 32'hE000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 32'hE000_0001, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    repeat (2) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    resetn = 1'b1;

    for (int k = 0; k < 6; k++) cyc(1'b1, 32'h300 + 32'(k * 4), $urandom, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
